// File: rtl/vga_timing_rx.sv
// vga_timing_rx
//   Receive-side timing recovery for a 640x480 style display stream. It watches
//   the incoming active-low h_sync/v_sync at pixel rate, rebuilds the pixel
//   position, checks line and frame lengths and reports when timing is locked.
//
// Ports
//   clk         in   pixel clock, all logic on the rising edge
//   rst_n       in   asynchronous active-low reset
//   h_sync      in   incoming horizontal sync, active low
//   v_sync      in   incoming vertical sync, active low
//   x_loc       out  recovered column (0 outside the active area)
//   y_loc       out  recovered row (0 outside the active area)
//   video_on    out  recovered pixel is visible and timing is locked
//   locked      out  timing verified for LOCK_FRAMES consecutive frames
//   frame_start out  one-cycle pulse on each frame start while tracking/locked
//   err_count   out  saturating count of timing errors since reset
module vga_timing_rx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [9:0] x_loc,
    output logic [9:0] y_loc,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic [7:0] err_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int GW      = $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SAT     = 11'(2 * H_TOTAL);
    localparam logic [10:0] H_START   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END     = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SAT     = 10'(V_TOTAL + 1);
    localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;

    state_e        state_q, state_d;
    logic          hsMeta_q, hsSync_q, hsDly_q;
    logic          vsMeta_q, vsSync_q, vsSamp_q, vsSamp_d;
    logic [10:0]   hCnt_q, hCnt_d;
    logic [9:0]    vCnt_q, vCnt_d;
    logic [GW-1:0] good_q, good_d;
    logic          hArmed_q, hArmed_d, vArmed_q, vArmed_d;
    logic [7:0]    errCnt_q, errCnt_d;
    logic [9:0]    xLoc_q, xLoc_d, yLoc_q, yLoc_d;
    logic          video_q, video_d, locked_q, locked_d, fs_q, fs_d;

    logic hFall, vFall, timeout, hErr, vErr, anyErr, hOn, vOn;

    // Event detection and counters. v_sync is only looked at on h-fall cycles
    // so a v_sync edge coinciding with the h_sync edge is seen on that line.
    always_comb begin
        hFall   = hsDly_q & ~hsSync_q;
        vFall   = hFall & vsSamp_q & ~vsSync_q;
        timeout = (hCnt_q == H_SAT);
        hErr    = hFall & hArmed_q & (hCnt_q != H_LAST);
        vErr    = vFall & vArmed_q & (vCnt_q != V_LAST);
        anyErr  = hErr | vErr | timeout;

        hCnt_d   = hCnt_q;
        vCnt_d   = vCnt_q;
        vsSamp_d = vsSamp_q;
        if (hFall) begin
            hCnt_d   = '0;
            vsSamp_d = vsSync_q;
            if (vFall) begin
                vCnt_d = '0;
            end else if (vCnt_q != V_SAT) begin
                vCnt_d = vCnt_q + 10'd1;
            end
        end else if (!timeout) begin
            hCnt_d = hCnt_q + 11'd1;
        end
    end

    // Lock FSM. An error while tracking or locked drops back to SEARCH, counts
    // once and disarms the length checks so the next partial line/frame is ignored.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        errCnt_d = errCnt_q;
        hArmed_d = hArmed_q | hFall;
        vArmed_d = vArmed_q | vFall;
        case (state_q)
            SEARCH: begin
                if (vFall) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK, LOCKED: begin
                if (anyErr) begin
                    state_d  = SEARCH;
                    good_d   = '0;
                    hArmed_d = 1'b0;
                    vArmed_d = 1'b0;
                    if (errCnt_q != 8'hFF) begin
                        errCnt_d = errCnt_q + 8'd1;
                    end
                end else if (vFall && state_q == TRACK) begin
                    good_d = good_q + GW'(1);
                    if (good_d == GOOD_LOCK) begin
                        state_d = LOCKED;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Registered outputs follow the next state so video_on never outlives locked.
    always_comb begin
        hOn      = (hCnt_q >= H_START) && (hCnt_q < H_END);
        vOn      = (vCnt_q >= V_START) && (vCnt_q < V_END);
        locked_d = (state_d == LOCKED);
        video_d  = locked_d & hOn & vOn;
        xLoc_d   = video_d ? 10'(hCnt_q - H_START) : 10'd0;
        yLoc_d   = video_d ? (vCnt_q - V_START) : 10'd0;
        fs_d     = vFall & (state_d != SEARCH);
    end

    // All state; synchronizer and sync-history flops idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsMeta_q <= 1'b1;
            hsSync_q <= 1'b1;
            hsDly_q  <= 1'b1;
            vsMeta_q <= 1'b1;
            vsSync_q <= 1'b1;
            vsSamp_q <= 1'b1;
            state_q  <= SEARCH;
            hCnt_q   <= '0;
            vCnt_q   <= '0;
            good_q   <= '0;
            hArmed_q <= 1'b0;
            vArmed_q <= 1'b0;
            errCnt_q <= '0;
            xLoc_q   <= '0;
            yLoc_q   <= '0;
            video_q  <= 1'b0;
            locked_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hsMeta_q <= h_sync;
            hsSync_q <= hsMeta_q;
            hsDly_q  <= hsSync_q;
            vsMeta_q <= v_sync;
            vsSync_q <= vsMeta_q;
            vsSamp_q <= vsSamp_d;
            state_q  <= state_d;
            hCnt_q   <= hCnt_d;
            vCnt_q   <= vCnt_d;
            good_q   <= good_d;
            hArmed_q <= hArmed_d;
            vArmed_q <= vArmed_d;
            errCnt_q <= errCnt_d;
            xLoc_q   <= xLoc_d;
            yLoc_q   <= yLoc_d;
            video_q  <= video_d;
            locked_q <= locked_d;
            fs_q     <= fs_d;
        end
    end

    assign x_loc       = xLoc_q;
    assign y_loc       = yLoc_q;
    assign video_on    = video_q;
    assign locked      = locked_q;
    assign frame_start = fs_q;
    assign err_count   = errCnt_q;

endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receive-side counterpart of the display timing generator: monitors incoming active-low h_sync/v_sync at pixel rate.
- Recovers the pixel position (x_loc, y_loc) and video_on, checks line and frame lengths against 640x480 timing, and reports lock.
- Used as a loopback checker on the generator outputs and as the front end of future capture logic.
- Runs on the divided pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- LOCK_FRAMES, 2, consecutive error-free frames needed to lock

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- h_sync  in  1  incoming horizontal sync, active low
- v_sync  in  1  incoming vertical sync, active low
- x_loc  out  10  recovered column 0..H_ACTIVE-1; 0 when video_on=0
- y_loc  out  10  recovered row 0..V_ACTIVE-1; 0 when video_on=0
- video_on  out  1  recovered pixel is in the active area and locked=1
- locked  out  1  timing verified
- frame_start  out  1  one-cycle pulse on each detected frame start (v-fall), in TRACK or LOCKED
- err_count  out  8  saturating count of timing errors since reset

Behaviour:
- Derived values:
  - H_TOTAL = sum of the H_* parameters = 800.
  - V_TOTAL = sum of the V_* parameters = 525.
- Reset: one asynchronous active-low reset.
  - Asserting rst_n=0 clears every register immediately, including mid-frame; all outputs go to 0 and the FSM goes to SEARCH.
  - Synchronizer flops reset to 1 (syncs idle high).
- Input path:
  - Each sync passes through a 2-flop synchronizer, then a 1-flop delay for edge detection.
  - h-fall = delayed 1 and synchronized 0.
  - Fixed latency: a raw h_sync fall before clk edge k makes recovered h position 0 at cycle k+3.
- h_cnt (11 bits):
  - Cleared on h-fall, otherwise increments.
  - Saturates at 2*H_TOTAL; reaching saturation is a timeout.
- Line length check: on each h-fall, the completed line length (h_cnt+1) must equal H_TOTAL, otherwise h_err. The first h-fall after SEARCH is not checked.
- Vertical sampling:
  - The synchronized v_sync is sampled only on h-fall cycles.
  - v-fall = previous sample 1 and current sample 0.
  - This tolerates v_sync changing in the same cycle as h_sync.
- v_cnt (10 bits):
  - On h-fall: cleared if v-fall, otherwise incremented.
  - Saturates at V_TOTAL+1.
- Frame length check: on v-fall, the completed frame (v_cnt+1 lines) must equal V_TOTAL, otherwise v_err. The first v-fall after SEARCH is not checked.
- Simultaneous events: h-fall with timeout in the same cycle counts as one error. At most one err_count increment per cycle.
- FSM states:
  - SEARCH: counters free-run; locked=0. Move to TRACK on the first v-fall, with good_frames=0.
  - TRACK: an error-free v-fall increments good_frames. When good_frames reaches LOCK_FRAMES, move to LOCKED on that same v-fall.
  - LOCKED: locked=1.
  - Any h_err, v_err or timeout in TRACK or LOCKED moves to SEARCH next cycle: locked=0, good_frames=0, err_count+1 (saturating at 255).
  - Errors in SEARCH are not counted.
- Position decode:
  - video_on = locked and H_SYNC+H_BP ≤ h_cnt < H_SYNC+H_BP+H_ACTIVE, and V_SYNC+V_BP ≤ v_cnt < V_SYNC+V_BP+V_ACTIVE.
  - x_loc = h_cnt-(H_SYNC+H_BP); y_loc = v_cnt-(V_SYNC+V_BP).
  - All outputs are registered.
- frame_start: asserted the cycle after the v-fall detection, in TRACK or LOCKED (including the v-fall that completes lock).

Test Plan:
- Reset: hold rst_n=0 with toggling syncs → all outputs 0; release with syncs high → outputs stay 0 until the first v-fall.
- Clean 640x480 stream from the timing generator model: frame_start on the 1st v-fall, locked=1 from the 3rd v-fall; in line 35, video_on rises with x_loc=0 at h position 144 and falls after x_loc=639; the last active pixel is y_loc=479 on line 514.
- One line of 801 clocks while locked → locked=0 at that h-fall+1, err_count=1, video_on=0; relock exactly LOCK_FRAMES+1 v-falls later.
- Frame of 524 lines while locked → v_err at that v-fall, locked=0, err_count increments by 1; a frame of 525 lines produces no error.
- h_sync held high for 1600+ clocks while locked → timeout, SEARCH, err_count+1; a repeated timeout in SEARCH does not increment err_count.
- rst_n pulsed low mid-frame while locked → outputs 0 asynchronously; after release, lock is reacquired following the SEARCH→TRACK→LOCKED sequence; err_count is 0.
